// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter serving NCPU core read/write requests on one memory port.
// Define ARB_TIMEOUT_EN to abort accesses that see no mem_ack within TIMEOUT cycles.
module mem_bus_arbiter #(
   parameter int unsigned NCPU       = 4,
   parameter int unsigned TIMEOUT    = 255,
   parameter int unsigned ADDR_SIZE0 = 31,
   parameter int unsigned DATA_SIZE0 = 31,
   localparam int unsigned A         = ADDR_SIZE0 + 1,
   localparam int unsigned D         = DATA_SIZE0 + 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NCPU-1:0]   cpu_read_q_i,
   input  logic [NCPU-1:0]   cpu_write_q_i,
   input  logic [NCPU*A-1:0] cpu_addr_i,
   input  logic [NCPU*D-1:0] cpu_wdata_i,
   output logic [NCPU-1:0]   cpu_read_dn_o,
   output logic [NCPU-1:0]   cpu_write_dn_o,
   output logic [D-1:0]      cpu_rdata_o,
   output logic [NCPU-1:0]   grant_o,
   output logic              bus_busy_o,
   output logic [A-1:0]      mem_addr_o,
   output logic [D-1:0]      mem_wdata_o,
   output logic              mem_rd_o,
   output logic              mem_wr_o,
   input  logic [D-1:0]      mem_rdata_i,
   input  logic              mem_ack_i,
   output logic              err_o
);

   localparam int unsigned IdxW = $clog2(NCPU);

   typedef enum logic [1:0] {StIdle, StAccess, StDone, StRelease} state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d, ptr_q, ptr_d;
   logic            is_wr_q, is_wr_d;
   logic [A-1:0]    addr_q, addr_d;
   logic [D-1:0]    wdata_q, wdata_d, rdata_q, rdata_d;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned     CntW    = (TIMEOUT > 255) ? 16 : 8;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            to_q, to_d;
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = TIMEOUT;
`endif

   logic [A-1:0] addr_arr  [NCPU];
   logic [D-1:0] wdata_arr [NCPU];

   for (genvar g = 0; g < NCPU; g++) begin : g_unpack
      assign addr_arr[g]  = cpu_addr_i[g*A +: A];
      assign wdata_arr[g] = cpu_wdata_i[g*D +: D];
   end

   // Round-robin search: first requester after ptr_q, wrapping modulo NCPU.
   logic [NCPU-1:0] req;
   logic            found;
   logic [IdxW-1:0] win, cand_idx;
   int unsigned     cand;

   always_comb begin
      req      = cpu_read_q_i | cpu_write_q_i;
      found    = 1'b0;
      win      = '0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned k = 0; k < NCPU; k++) begin
         cand = 32'(ptr_q) + k + 32'd1;
         if (cand >= NCPU) cand = cand - NCPU;
         cand_idx = cand[IdxW-1:0];
         if (!found && req[cand_idx]) begin
            found = 1'b1;
            win   = cand_idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      is_wr_d = is_wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      to_d    = to_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d = StAccess;
               idx_d   = win;
               ptr_d   = win;
               is_wr_d = cpu_write_q_i[win];
               addr_d  = addr_arr[win];
               wdata_d = wdata_arr[win];
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
               to_d    = 1'b0;
`endif
            end
         end
         StAccess: begin
            if (mem_ack_i) begin
               state_d = StDone;
               if (!is_wr_q) rdata_d = mem_rdata_i;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == CntLast) begin
               state_d = StDone;
               to_d    = 1'b1;
               rdata_d = '1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         StDone: state_d = StRelease;
         // Hold the grant until the served line drops so it is not served twice.
         StRelease: begin
            if (!(is_wr_q ? cpu_write_q_i[idx_q] : cpu_read_q_i[idx_q])) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      grant_o        = '0;
      bus_busy_o     = 1'b0;
      mem_rd_o       = 1'b0;
      mem_wr_o       = 1'b0;
      cpu_read_dn_o  = '0;
      cpu_write_dn_o = '0;
      cpu_rdata_o    = '0;
      err_o          = 1'b0;
      if (state_q != StIdle) begin
         grant_o[idx_q] = 1'b1;
         bus_busy_o     = 1'b1;
      end
      if (state_q == StAccess) begin
         mem_rd_o = !is_wr_q;
         mem_wr_o = is_wr_q;
      end
      if (state_q == StDone) begin
         if (is_wr_q) begin
            cpu_write_dn_o[idx_q] = 1'b1;
         end else begin
            cpu_read_dn_o[idx_q] = 1'b1;
            cpu_rdata_o          = rdata_q;
         end
`ifdef ARB_TIMEOUT_EN
         err_o = to_q;
`endif
      end
   end

   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         idx_q   <= '0;
         ptr_q   <= IdxW'(NCPU - 1);
         is_wr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= '0;
         to_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         is_wr_q <= is_wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         to_q    <= to_d;
`endif
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed corner cases, then random core traffic checked
// against a transaction-level round-robin model.
module tb_mem_bus_arbiter;
   localparam int unsigned NCPU    = 4;
   localparam int unsigned IW      = $clog2(NCPU);
   localparam int unsigned A       = 32;
   localparam int unsigned D       = 32;
   localparam int unsigned TIMEOUT = 4;
   localparam int MIdle = 0, MAcc = 1, MDn = 2, MRel = 3;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   logic [NCPU-1:0]   rd_req = '0, wr_req = '0;
   logic [A-1:0]      addr_v  [NCPU];
   logic [D-1:0]      wdata_v [NCPU];
   logic [NCPU*A-1:0] cpu_addr;
   logic [NCPU*D-1:0] cpu_wdata;
   logic [NCPU-1:0]   cpu_read_dn, cpu_write_dn, grant;
   logic [D-1:0]      cpu_rdata, mem_wdata;
   logic [A-1:0]      mem_addr;
   logic              bus_busy, mem_rd, mem_wr, err;
   logic [D-1:0]      mem_rdata = '0;
   logic              mem_ack = 1'b0;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk_i = ~clk_i;

   always_comb begin
      cpu_addr  = '0;
      cpu_wdata = '0;
      for (int i = 0; i < NCPU; i++) begin
         cpu_addr[i*A +: A]  = addr_v[i];
         cpu_wdata[i*D +: D] = wdata_v[i];
      end
   end

   mem_bus_arbiter #(.NCPU(NCPU), .TIMEOUT(TIMEOUT)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .cpu_read_q_i   (rd_req),
      .cpu_write_q_i  (wr_req),
      .cpu_addr_i     (cpu_addr),
      .cpu_wdata_i    (cpu_wdata),
      .cpu_read_dn_o  (cpu_read_dn),
      .cpu_write_dn_o (cpu_write_dn),
      .cpu_rdata_o    (cpu_rdata),
      .grant_o        (grant),
      .bus_busy_o     (bus_busy),
      .mem_addr_o     (mem_addr),
      .mem_wdata_o    (mem_wdata),
      .mem_rd_o       (mem_rd),
      .mem_wr_o       (mem_wr),
      .mem_rdata_i    (mem_rdata),
      .mem_ack_i      (mem_ack),
      .err_o          (err)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Pending core closest after ptr (cyclically) wins; -1 when nothing pends.
   function automatic int rr_pick(input int ptr, input logic [NCPU-1:0] pend);
      int best   = -1;
      int best_d = NCPU;
      for (int i = 0; i < NCPU; i++) begin
         if (pend[i[IW-1:0]]) begin
            int d = (i - ptr - 1 + 2 * NCPU) % NCPU;
            if (d < best_d) begin
               best_d = d;
               best   = i;
            end
         end
      end
      return best;
   endfunction

   initial begin
      int mode, nw, win, ptr_m, wait_left, hold, kind;
      bit rel_first, do_acc, win_wr;
      logic [NCPU-1:0] g_exp, exp_rdn, exp_wdn;
      logic [D-1:0]    exp_rdata, ack_data, wd_exp;
      logic [A-1:0]    a_exp;

      for (int i = 0; i < NCPU; i++) begin
         addr_v[i]  = '0;
         wdata_v[i] = '0;
      end

      // Reset values
      repeat (2) @(negedge clk_i);
      check_eq("rst_grant_busy", {grant, bus_busy}, 0);
      check_eq("rst_strobes", {mem_rd, mem_wr, err}, 0);
      check_eq("rst_dn", {cpu_read_dn, cpu_write_dn}, 0);
      check_eq("rst_data", {cpu_rdata, mem_addr, mem_wdata}, 0);
      rst_ni = 1'b1;

      // Single read from core 2, ack one cycle after the strobe
      @(negedge clk_i);
      rd_req[2] = 1'b1;
      addr_v[2] = 32'h100;
      @(negedge clk_i);
      check_eq("rd_grant", {grant, bus_busy, mem_rd, mem_wr}, {4'b0100, 1'b1, 1'b1, 1'b0});
      check_eq("rd_addr", mem_addr, 32'h100);
      @(negedge clk_i);
      check_eq("rd_wait", {mem_rd, cpu_read_dn}, {1'b1, 4'b0000});
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      @(negedge clk_i);
      mem_ack = 1'b0;
      check_eq("rd_dn", {cpu_read_dn, cpu_write_dn, mem_rd}, {4'b0100, 4'b0000, 1'b0});
      check_eq("rd_data", cpu_rdata, 32'hDEADBEEF);
      rd_req[2] = 1'b0;
      @(negedge clk_i);
      check_eq("rd_release", {grant, bus_busy, cpu_read_dn, cpu_rdata}, {4'b0100, 1'b1, 4'b0, 32'h0});
      @(negedge clk_i);
      check_eq("rd_idle", {grant, bus_busy}, 0);

      // Stalled access: timeout abort, or an indefinite wait without the feature
      rd_req[1] = 1'b1;
      addr_v[1] = 32'h2000;
      @(negedge clk_i);
      check_eq("stall_grant", {grant, mem_rd}, {4'b0010, 1'b1});
`ifdef ARB_TIMEOUT_EN
      for (int c = 0; c < TIMEOUT - 1; c++) begin
         @(negedge clk_i);
         check_eq("to_wait", {mem_rd, cpu_read_dn, err}, {1'b1, 4'b0000, 1'b0});
      end
      @(negedge clk_i);
      check_eq("to_dn", {cpu_read_dn, err, mem_rd}, {4'b0010, 1'b1, 1'b0});
      check_eq("to_data", cpu_rdata, 32'hFFFFFFFF);
`else
      for (int c = 0; c < 100; c++) begin
         @(negedge clk_i);
         check_eq("hold_wait", {mem_rd, grant, cpu_read_dn, err}, {1'b1, 4'b0010, 4'b0000, 1'b0});
      end
      mem_ack   = 1'b1;
      mem_rdata = 32'h12345678;
      @(negedge clk_i);
      mem_ack = 1'b0;
      check_eq("hold_dn", {cpu_read_dn, err}, {4'b0010, 1'b0});
      check_eq("hold_data", cpu_rdata, 32'h12345678);
`endif
      rd_req[1] = 1'b0;
      repeat (2) @(negedge clk_i);
      check_eq("stall_idle", {grant, bus_busy}, 0);

      // Asynchronous reset while core 3 waits for mem_ack
      rd_req[3] = 1'b1;
      addr_v[3] = 32'h300;
      @(negedge clk_i);
      check_eq("arst_grant", {grant, mem_rd}, {4'b1000, 1'b1});
      #2 rst_ni = 1'b0;
      #1 check_eq("arst_out", {mem_rd, mem_wr, grant, bus_busy}, 0);
      @(negedge clk_i);
      check_eq("arst_no_dn", {cpu_read_dn, cpu_write_dn}, 0);
      rst_ni    = 1'b1;
      rd_req[0] = 1'b1;
      addr_v[0] = 32'h40;
      @(negedge clk_i);
      check_eq("arst_prio", grant, 4'b0001);
      mem_ack   = 1'b1;
      mem_rdata = 32'hCAFE0000;
      @(negedge clk_i);
      mem_ack = 1'b0;
      check_eq("arst_dn", {cpu_read_dn, cpu_rdata}, {4'b0001, 32'hCAFE0000});
      rd_req[0] = 1'b0;
      repeat (3) @(negedge clk_i);
      check_eq("arst_next", grant, 4'b1000);
      rst_ni = 1'b0;
      rd_req = '0;
      wr_req = '0;
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Random traffic against the transaction model
      mode      = MIdle;
      ptr_m     = NCPU - 1;
      win       = 0;
      win_wr    = 1'b0;
      g_exp     = '0;
      wait_left = 0;
      hold      = 0;
      rel_first = 1'b0;
      ack_data  = '0;
      a_exp     = '0;
      wd_exp    = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk_i);
         exp_rdn   = '0;
         exp_wdn   = '0;
         exp_rdata = '0;
         if (mode == MDn) begin
            if (win_wr) begin
               exp_wdn = g_exp;
            end else begin
               exp_rdn   = g_exp;
               exp_rdata = ack_data;
            end
         end
         check_eq("read_dn", cpu_read_dn, exp_rdn);
         check_eq("write_dn", cpu_write_dn, exp_wdn);
         check_eq("rdata", cpu_rdata, exp_rdata);
         check_eq("err", err, 1'b0);
         mem_ack = 1'b0;
         do_acc  = 1'b0;
         case (mode)
            MIdle: begin
               nw = rr_pick(ptr_m, rd_req | wr_req);
               if (nw < 0) begin
                  check_eq("idle", {grant, bus_busy, mem_rd, mem_wr}, 0);
               end else begin
                  win       = nw;
                  g_exp     = NCPU'(1) << nw;
                  win_wr    = |(wr_req & g_exp);
                  ptr_m     = nw;
                  a_exp     = addr_v[nw];
                  wd_exp    = wdata_v[nw];
                  wait_left = $urandom_range(0, 3);
                  mode      = MAcc;
                  do_acc    = 1'b1;
               end
            end
            MAcc: do_acc = 1'b1;
            MDn: begin
               check_eq("done_hold", {grant, bus_busy, mem_rd, mem_wr}, {g_exp, 1'b1, 2'b00});
               hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
               if (hold == 0) begin
                  if (win_wr) wr_req = wr_req & ~g_exp;
                  else rd_req = rd_req & ~g_exp;
               end
               mode      = MRel;
               rel_first = 1'b1;
            end
            default: begin
               if (rel_first) begin
                  check_eq("rel_first", {grant, bus_busy, mem_rd, mem_wr}, {g_exp, 1'b1, 2'b00});
                  rel_first = 1'b0;
               end else if (!(|((win_wr ? wr_req : rd_req) & g_exp))) begin
                  check_eq("rel_exit", {grant, bus_busy}, 0);
                  mode = MIdle;
               end else begin
                  check_eq("rel_held", {grant, bus_busy, mem_rd, mem_wr}, {g_exp, 1'b1, 2'b00});
               end
               if (mode == MRel && hold > 0) begin
                  hold--;
                  if (hold == 0) begin
                     if (win_wr) wr_req = wr_req & ~g_exp;
                     else rd_req = rd_req & ~g_exp;
                  end
               end
            end
         endcase
         if (do_acc) begin
            check_eq("acc_grant", {grant, bus_busy}, {g_exp, 1'b1});
            check_eq("acc_strobe", {mem_rd, mem_wr}, {!win_wr, win_wr});
            check_eq("acc_addr", mem_addr, a_exp);
            if (win_wr) check_eq("acc_wdata", mem_wdata, wd_exp);
            if (wait_left == 0) begin
               ack_data  = $urandom;
               mem_rdata = ack_data;
               mem_ack   = 1'b1;
               mode      = MDn;
            end else begin
               wait_left--;
            end
         end
         // Stray acks outside an access must be ignored.
         if ((mode == MIdle || mode == MRel) && $urandom_range(0, 7) == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
         end
         for (int i = 0; i < NCPU; i++) begin
            if (!rd_req[i] && !wr_req[i] && !(mode == MRel && i == win) &&
                $urandom_range(0, 3) == 0) begin
               kind       = $urandom_range(0, 7);
               addr_v[i]  = $urandom;
               wdata_v[i] = $urandom;
               if (kind == 0) begin
                  rd_req[i] = 1'b1;
                  wr_req[i] = 1'b1;
               end else if (kind < 4) begin
                  rd_req[i] = 1'b1;
               end else begin
                  wr_req[i] = 1'b1;
               end
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
